// File: rtl/bios_loader.sv
// BIOS image loader: packs SPI download bytes into 16-bit words, double-buffers them
// in two ping-pong banks and drains full banks over the bios_wr/bios_req handshake.
// Optional: define BIOS_LOADER_CHECKSUM_EN to add a running 16-bit checksum output.
module bios_loader #(
  parameter int unsigned BANK_WORDS = 32,
  parameter logic [15:0] PAD_WORD   = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        bios_req,
  output logic        bios_wr,
  output logic [13:0] bios_addr,
  output logic [15:0] bios_din,
  output logic        bios_loaded,
  output logic        overflow
`ifdef BIOS_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int unsigned AW = $clog2(BANK_WORDS);
  localparam logic [AW-1:0] LAST = AW'(BANK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t state, state_n;

  logic [15:0]                mem [2][BANK_WORDS];
  logic [1:0][BANK_WORDS-1:0] wvld;
  logic [1:0]                 full, anyw;
  logic                       rbank, last_bank, lo_pend, fin_pend, dl_q;
  logic [AW-1:0]              rptr, lo_idx;
  logic [7:0]                 lo_byte;
  logic [13:0]                next_addr;

  logic          rise, fall, addr_hi, wbank, wr_ok, drop;
  logic [AW-1:0] widx;
  logic          take, wrap, flip, finish;
  logic          mem_we;
  logic          mem_wb;
  logic [AW-1:0] mem_wi;
  logic [15:0]   mem_wd, rd_word;
  logic          unused_addr;

  assign rise    = ioctl_download & ~dl_q;
  assign fall    = ~ioctl_download & dl_q;
  assign addr_hi = |ioctl_addr[24:15];
  assign wbank   = ioctl_addr[AW+1];
  assign widx    = ioctl_addr[AW:1];
  assign wr_ok   = ioctl_download & ioctl_wr & ~addr_hi & ~full[wbank];
  assign drop    = ioctl_download & ioctl_wr & (addr_hi | full[wbank]);
  assign rd_word = wvld[rbank][rptr] ? mem[rbank][rptr] : PAD_WORD;
  assign unused_addr = ^ioctl_addr[14:AW+2];

  // Completed pairs write during download; a dangling even byte is closed out at the falling edge
  always_comb begin
    mem_we = 1'b0;
    mem_wb = wbank;
    mem_wi = widx;
    mem_wd = {ioctl_dout, lo_byte};
    if (wr_ok && ioctl_addr[0]) begin
      mem_we = 1'b1;
    end else if (fall && lo_pend) begin
      mem_we = 1'b1;
      mem_wb = last_bank;
      mem_wi = lo_idx;
      mem_wd = {8'hFF, lo_byte};
    end
  end

  always_ff @(posedge clk_sys)
    if (mem_we) mem[mem_wb][mem_wi] <= mem_wd;

  always_ff @(posedge clk_sys)
    if (reset) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n = state;
    take    = 1'b0;
    wrap    = 1'b0;
    flip    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE:
        if (full[rbank])       state_n = DRAIN;
        else if (full[~rbank]) flip = 1'b1;  // out-of-order fill: never strand a full bank
        else if (fin_pend) begin
          state_n = DONE;
          finish  = 1'b1;
        end
      DRAIN:
        if (bios_req) begin
          take = 1'b1;
          if (rptr == LAST) begin
            wrap = 1'b1;
            if (!full[~rbank]) state_n = IDLE;
          end
        end
      default: ;
    endcase
    if (rise) begin
      state_n = IDLE;
      take    = 1'b0;
      wrap    = 1'b0;
      flip    = 1'b0;
      finish  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q <= 1'b0;  full <= '0;  anyw <= '0;  wvld <= '0;
      rbank <= 1'b0;  rptr <= '0;  next_addr <= '0;
      last_bank <= 1'b0;  lo_pend <= 1'b0;  lo_byte <= '0;  lo_idx <= '0;
      fin_pend <= 1'b0;  bios_wr <= 1'b0;  bios_addr <= '0;  bios_din <= '0;
      bios_loaded <= 1'b0;  overflow <= 1'b0;
`ifdef BIOS_LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      dl_q    <= ioctl_download;
      bios_wr <= (state_n == DRAIN);
      if (take) begin
        bios_din  <= rd_word;
        bios_addr <= next_addr;
        next_addr <= next_addr + 14'd1;
        rptr      <= rptr + 1'b1;
`ifdef BIOS_LOADER_CHECKSUM_EN
        checksum  <= checksum + rd_word;
`endif
      end
      if (wrap || flip) rbank <= ~rbank;
      if (wrap) begin
        full[rbank] <= 1'b0;
        anyw[rbank] <= 1'b0;
        wvld[rbank] <= '0;
      end
      if (finish) begin
        bios_loaded <= 1'b1;
        fin_pend    <= 1'b0;
      end
      if (wr_ok) begin
        last_bank <= wbank;
        if (!ioctl_addr[0]) begin
          lo_byte <= ioctl_dout;
          lo_idx  <= widx;
          lo_pend <= 1'b1;
        end else begin
          lo_pend           <= 1'b0;
          anyw[wbank]       <= 1'b1;
          wvld[wbank][widx] <= 1'b1;
          if (widx == LAST) full[wbank] <= 1'b1;
        end
      end
      if (drop) overflow <= 1'b1;
      // Unwritten words of a flushed bank read back as PAD_WORD through wvld
      if (fall) begin
        fin_pend <= 1'b1;
        lo_pend  <= 1'b0;
        if (lo_pend) begin
          anyw[last_bank]         <= 1'b1;
          wvld[last_bank][lo_idx] <= 1'b1;
        end
        if ((anyw[last_bank] || lo_pend) && !full[last_bank]) full[last_bank] <= 1'b1;
      end
      if (rise) begin
        full <= '0;  anyw <= '0;  wvld <= '0;
        rbank <= 1'b0;  rptr <= '0;  next_addr <= '0;
        lo_pend <= 1'b0;  fin_pend <= 1'b0;
        overflow <= 1'b0;  bios_loaded <= 1'b0;
`ifdef BIOS_LOADER_CHECKSUM_EN
        checksum <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bios_loader.sv
// Directed bench for bios_loader: drains, padding, back-pressure, overflow and reset.
module tb_bios_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        bios_req = 1'b0;
  logic        bios_wr;
  logic [13:0] bios_addr;
  logic [15:0] bios_din;
  logic        bios_loaded;
  logic        overflow;
`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  bios_loader dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .bios_req(bios_req), .bios_wr(bios_wr), .bios_addr(bios_addr),
    .bios_din(bios_din), .bios_loaded(bios_loaded), .overflow(overflow)
`ifdef BIOS_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int errs = 0;
  int checks = 0;

  // Consumer-side monitor: a word is consumed at the edge after a negedge with bios_wr&bios_req
  logic [29:0] cap_q[$];
  logic take_pend = 1'b0;
  logic wr_prev = 1'b0;
  int   wr_cnt = 0;
  int   wr_falls = 0;

  always @(negedge clk_sys) begin
    if (take_pend) cap_q.push_back({bios_addr, bios_din});
    take_pend = bios_wr && bios_req;
    if (bios_wr) wr_cnt++;
    if (wr_prev && !bios_wr) wr_falls++;
    wr_prev = bios_wr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick(1);
    ioctl_wr   = 1'b0;
  endtask

  task automatic dl_start();
    ioctl_download = 1'b1;
    tick(1);
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    tick(1);
  endtask

  task automatic clear_mon();
    cap_q.delete();
    wr_cnt   = 0;
    wr_falls = 0;
  endtask

  task automatic wait_loaded(input string tag);
    for (int n = 0; n < 400 && !bios_loaded; n++) tick(1);
    chk(tag, {31'd0, bios_loaded}, 32'd1);
  endtask

  task automatic cap_word(input int k, output logic [31:0] w);
    if (k < cap_q.size()) w = {2'b00, cap_q[k]};
    else                  w = 32'hDEADBEEF;
  endtask

  // Ascending-byte image: word k = {2k+1, 2k} for k < nvalid, PAD beyond
  task automatic chk_words(input string tag, input int n, input int nvalid);
    logic [31:0] w, e;
    logic [7:0] lo, hi;
    for (int k = 0; k < n; k++) begin
      cap_word(k, w);
      lo = 8'(2 * k);
      hi = 8'(2 * k + 1);
      e = (k < nvalid) ? {2'b00, 14'(k), hi, lo} : {2'b00, 14'(k), 16'hFFFF};
      chk($sformatf("%s[%0d]", tag, k), w, e);
    end
  endtask

  initial begin
    logic [31:0] w;

    // Reset state
    tick(3);
    chk("rst_bios_wr", {31'd0, bios_wr}, 32'd0);
    chk("rst_bios_addr", {18'd0, bios_addr}, 32'd0);
    chk("rst_bios_din", {16'd0, bios_din}, 32'd0);
    chk("rst_loaded", {31'd0, bios_loaded}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick(2);

    // 64-byte image, consumer always ready
    bios_req = 1'b1;
    clear_mon();
    dl_start();
    for (int i = 0; i < 64; i++) wr_byte(25'(i), 8'(i));
    tick(40);
    dl_end();
    wait_loaded("t1_loaded");
    chk("t1_wr_cycles", wr_cnt, 32'd32);
    chk("t1_nwords", cap_q.size(), 32'd32);
    chk_words("t1_word", 32, 32);
    chk("t1_overflow", {31'd0, overflow}, 32'd0);

    // 70-byte image: second bank padded on flush
    clear_mon();
    dl_start();
    chk("t2_loaded_clr", {31'd0, bios_loaded}, 32'd0);
    for (int i = 0; i < 70; i++) wr_byte(25'(i), 8'(i));
    tick(40);
    dl_end();
    wait_loaded("t2_loaded");
    chk("t2_wr_cycles", wr_cnt, 32'd64);
    chk("t2_nwords", cap_q.size(), 32'd64);
    chk_words("t2_word", 64, 35);

    // 128 bytes with consumer stalled, then back-to-back drain
    bios_req = 1'b0;
    clear_mon();
    dl_start();
    for (int i = 0; i < 128; i++) wr_byte(25'(i), 8'(i));
    tick(5);
    chk("t3_overflow", {31'd0, overflow}, 32'd0);
    chk("t3_wr_waiting", {31'd0, bios_wr}, 32'd1);
    dl_end();
    tick(5);
    chk("t3_not_loaded", {31'd0, bios_loaded}, 32'd0);
    clear_mon();
    bios_req = 1'b1;
    wait_loaded("t3_loaded");
    chk("t3_wr_cycles", wr_cnt, 32'd64);
    chk("t3_wr_falls", wr_falls, 32'd1);
    chk("t3_nwords", cap_q.size(), 32'd64);
    chk_words("t3_word", 64, 64);

    // Both banks full, extra byte dropped
    bios_req = 1'b0;
    clear_mon();
    dl_start();
    for (int i = 0; i < 128; i++) wr_byte(25'(i), 8'(i) ^ 8'hA5);
    wr_byte(25'd128, 8'h55);
    tick(1);
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    dl_end();
    bios_req = 1'b1;
    wait_loaded("t4_loaded");
    chk("t4_nwords", cap_q.size(), 32'd64);
    cap_word(0, w);
    chk("t4_word0", w, {2'b00, 14'd0, 16'hA4A5});
    cap_word(63, w);
    chk("t4_word63", w, {2'b00, 14'd63, 16'hDADB});

    // Reset mid-drain, then a fresh 4-byte image
    bios_req = 1'b0;
    dl_start();
    for (int i = 0; i < 64; i++) wr_byte(25'(i), 8'(i));
    tick(3);
    clear_mon();
    bios_req = 1'b1;
    for (int n = 0; n < 100 && cap_q.size() < 10; n++) tick(1);
    chk("t5_mid_drain", {31'd0, cap_q.size() >= 10}, 32'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick(1);
    chk("t5_rst_wr", {31'd0, bios_wr}, 32'd0);
    chk("t5_rst_addr", {18'd0, bios_addr}, 32'd0);
    chk("t5_rst_din", {16'd0, bios_din}, 32'd0);
    chk("t5_rst_loaded", {31'd0, bios_loaded}, 32'd0);
    chk("t5_rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick(1);
    clear_mon();
    dl_start();
    wr_byte(25'd0, 8'h01);
    wr_byte(25'd1, 8'h00);
    wr_byte(25'd2, 8'h02);
    wr_byte(25'd3, 8'h00);
    tick(2);
    dl_end();
    wait_loaded("t5_loaded");
    chk("t5_nwords", cap_q.size(), 32'd32);
    cap_word(0, w);
    chk("t5_word0", w, {2'b00, 14'd0, 16'h0001});
    cap_word(1, w);
    chk("t5_word1", w, {2'b00, 14'd1, 16'h0002});
    cap_word(31, w);
    chk("t5_word31", w, {2'b00, 14'd31, 16'hFFFF});
`ifdef BIOS_LOADER_CHECKSUM_EN
    chk("t5_checksum", {16'd0, checksum}, 32'h0000FFE5);
`endif

    // Out-of-range byte: dropped, empty image loads without a drain
    clear_mon();
    dl_start();
    wr_byte(25'd32768, 8'h12);
    tick(1);
    chk("t6_overflow", {31'd0, overflow}, 32'd1);
    dl_end();
    wait_loaded("t6_loaded");
    chk("t6_no_drain", wr_cnt, 32'd0);
    dl_start();
    chk("t6_ovf_clr", {31'd0, overflow}, 32'd0);
    chk("t6_loaded_clr", {31'd0, bios_loaded}, 32'd0);
    dl_end();
    tick(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
